div_unit: RTL and testbench

Sequential 32-bit signed integer divider for the CPU datapath; the inverse operation of the multi-cycle Booth multiplier and writes into the same Hi/Lo register pair. One start pulse launches a restoring shift-subtract division of DivA by DivB. After a fixed latency the block writes quotient to Lo and remainder to Hi and pulses `out`, which the control unit uses to leave its stall state.

---
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential 32-bit signed restoring divider writing Hi/Lo
//
// Ports:
//   Clk        in   1  clock, rising edge
//   Reset      in   1  asynchronous active-low reset
//   DivA       in  32  dividend (signed)
//   DivB       in  32  divisor (signed)
//   DivControl in   1  start request, sampled only in IDLE
//   Hi         out 32  remainder of last successful division
//   Lo         out 32  quotient of last successful division
//   out        out  1  one-cycle done pulse
//   DivZero    out  1  divide-by-zero flag, valid while out=1
//   busy       out  1  high from start acceptance until the out cycle ends

module div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] DivA,
  input  logic [31:0] DivB,
  input  logic        DivControl,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        out,
  output logic        DivZero,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [31:0] q;
  logic [31:0] divisor;
  logic [32:0] r;
  logic [5:0]  cnt;
  logic        sq;
  logic        sr;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] r_shift;
  logic [32:0] trial;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  assign abs_a = DivA[31] ? (~DivA + 32'd1) : DivA;
  assign abs_b = DivB[31] ? (~DivB + 32'd1) : DivB;

  // r stays below the divisor (at most 2^31), so the shifted value fits in
  // 32 bits and bit 32 of the trial difference is a clean sign bit.
  assign r_shift = {r[31:0], q[31]};
  assign trial   = r_shift - {1'b0, divisor};

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      q       <= 32'd0;
      divisor <= 32'd0;
      r       <= 33'd0;
      cnt     <= 6'd0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      Hi      <= 32'd0;
      Lo      <= 32'd0;
      out     <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DivControl) begin
            if (DivB == 32'd0) begin
              DivZero <= 1'b1;
              state   <= DONE;
            end else begin
              q       <= abs_a;
              divisor <= abs_b;
              sq      <= DivA[31] ^ DivB[31];
              sr      <= DivA[31];
              cnt     <= 6'd0;
              r       <= 33'd0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[32]) begin
            r <= trial;
            q <= {q[30:0], 1'b1};
          end else begin
            r <= r_shift;
            q <= {q[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          Lo    <= sq ? (~q + 32'd1) : q;
          Hi    <= sr ? (~r[31:0] + 32'd1) : r[31:0];
          state <= DONE;
        end
        DONE: begin
          // out is registered: the first DONE cycle raises it, the second
          // clears it and leaves, so busy covers the whole out cycle.
          if (!out) begin
            out <= 1'b1;
          end else begin
            out     <= 1'b0;
            DivZero <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit

module tb_div_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] DivA;
  logic [31:0] DivB;
  logic        DivControl;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        out;
  logic        DivZero;
  logic        busy;

  div_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .DivA       (DivA),
    .DivB       (DivB),
    .DivControl (DivControl),
    .Hi         (Hi),
    .Lo         (Lo),
    .out        (out),
    .DivZero    (DivZero),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] last_lo = 32'd0;
  logic [31:0] last_hi = 32'd0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi);
    logic [31:0] ma, mb, mq, mr;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    mq = ma / mb;
    mr = ma % mb;
    lo = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
    hi = a[31] ? (32'd0 - mr) : mr;
  endfunction

  // Output monitor: every out pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (out) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", Lo, e.lo);
        check("hi", Hi, e.hi);
        check("divzero", {31'd0, DivZero}, {31'd0, e.dz});
        check("latency", cyc, e.due);
        check("busy_during_out", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge Clk);
    if (b == 32'd0) begin
      e.lo  = last_lo;
      e.hi  = last_hi;
      e.dz  = 1'b1;
      e.due = cyc + 2;
    end else begin
      model(a, b, e.lo, e.hi);
      e.dz    = 1'b0;
      e.due   = cyc + 35;
      last_lo = e.lo;
      last_hi = e.hi;
    end
    sb.push_back(e);
    DivA       = a;
    DivB       = b;
    DivControl = 1'b1;
    @(negedge Clk);
    DivControl = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    start_div(a, b);
    wait_done();
  endtask

  initial begin
    Reset      = 1'b0;
    DivA       = 32'd0;
    DivB       = 32'd0;
    DivControl = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_divzero", {31'd0, DivZero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    run(32'd100, 32'd7);
    run(32'hFFFF_FFF9, 32'd2);
    run(32'd7, 32'hFFFF_FFFE);
    run(32'hFFFF_FFF9, 32'hFFFF_FFFE);

    // Divide by zero must leave the 9/4 result in place.
    run(32'd9, 32'd4);
    run(32'd5, 32'd0);

    run(32'h8000_0000, 32'hFFFF_FFFF);
    run(32'd0, 32'd5);
    run(32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb = {28'd0, rb[3:0]};
      if (rb == 32'd0) rb = 32'd3;
      run(ra, rb);
    end

    // A second start while busy must be ignored.
    start_div(32'd1000, 32'd3);
    repeat (8) @(negedge Clk);
    check("busy_mid_calc", {31'd0, busy}, 32'd1);
    DivA       = 32'd8;
    DivB       = 32'd2;
    DivControl = 1'b1;
    @(negedge Clk);
    DivControl = 1'b0;
    wait_done();
    repeat (40) @(negedge Clk);

    // Reset mid-calculation aborts with no write and no out.
    start_div(32'd1000, 32'd3);
    repeat (13) @(negedge Clk);
    Reset = 1'b0;
    sb.delete();
    last_lo = 32'd0;
    last_hi = 32'd0;
    @(negedge Clk);
    check("midrst_hi", Hi, 32'd0);
    check("midrst_lo", Lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    Reset = 1'b1;
    repeat (40) @(negedge Clk);
    check("midrst_hi_held", Hi, 32'd0);
    run(32'd50, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
